// File: rtl/instr_sequencer.sv
// Program sequencer for the 8-bit CPU core: buffers a host-loaded program and issues
// each word for a fixed number of cycles, with free-run, single-step and abort.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH  = 20,
  parameter int                     PC_BITS      = 4,
  parameter int                     ISSUE_CYCLES = 3,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [PC_BITS-1:0]     end_addr,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_STEP, FINISH} state_e;

  localparam logic [3:0] HOLD_LAST = 4'(ISSUE_CYCLES - 1);

  state_e                   state_q;
  logic [PC_BITS-1:0]       pc_q;
  logic [PC_BITS-1:0]       end_q;
  logic                     step_mode_q;
  logic [3:0]               hold_q;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic [INSTR_WIDTH-1:0]   mem_q [2**PC_BITS];

  logic [PC_BITS-1:0]       pc_inc_d;
  logic [INSTR_WIDTH-1:0]   word0_d;
  logic [INSTR_WIDTH-1:0]   next_word_d;
  logic [INSTR_WIDTH-1:0]   cur_word_d;

  assign pc_inc_d    = pc_q + PC_BITS'(1);
  // A host write to address 0 in the start cycle must be the word that issues first.
  assign word0_d     = (load_en && load_addr == '0) ? load_data : mem_q[0];
  assign next_word_d = mem_q[pc_inc_d];
  assign cur_word_d  = mem_q[pc_q];

  // Program buffer: host-writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && load_en && state_q == IDLE) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      hold_q  <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            end_q       <= end_addr;
            step_mode_q <= step_mode;
            pc_q        <= '0;
            hold_q      <= '0;
            instr_q     <= word0_d;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            state_q <= IDLE;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            // Finishing before the increment keeps pc from wrapping at the top address.
            if (pc_q == end_q) begin
              state_q <= FINISH;
              instr_q <= NOP_INSTR;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_inc_d;
              if (step_mode_q) begin
                state_q <= WAIT_STEP;
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
              end else begin
                instr_q <= next_word_d;
              end
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        WAIT_STEP: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step) begin
            state_q <= ISSUE;
            hold_q  <= '0;
            instr_q <= cur_word_d;
            valid_q <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: two instances (hold of 3 and of 1 cycle) share stimulus and are
// compared every cycle against a program-level model, plus directed literal checks.
module tb_instr_sequencer;

  localparam int ICA = 3;
  localparam int ICB = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [19:0] load_data = '0;
  logic        start = 1'b0;
  logic [3:0]  end_addr = '0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        abort = 1'b0;

  logic [19:0] a_ins, b_ins;
  logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [3:0]  a_pc, b_pc;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_sequencer #(.INSTR_WIDTH(20), .PC_BITS(4), .ISSUE_CYCLES(ICA), .NOP_INSTR(20'h00000)) dut_a (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .end_addr(end_addr), .step_mode(step_mode), .step(step), .abort(abort),
    .instruction(a_ins), .instr_valid(a_valid), .pc(a_pc), .busy(a_busy), .done(a_done));

  instr_sequencer #(.INSTR_WIDTH(20), .PC_BITS(4), .ISSUE_CYCLES(ICB), .NOP_INSTR(20'h00000)) dut_b (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .end_addr(end_addr), .step_mode(step_mode), .step(step), .abort(abort),
    .instruction(b_ins), .instr_valid(b_valid), .pc(b_pc), .busy(b_busy), .done(b_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [19:0] word(input int i);
    return {4'(i + 1), 16'(i + 1)};
  endfunction

  // Model: mode 0 idle, 1 presenting a word, 2 waiting for step, 3 completion cycle.
  int          mmode [2];
  int          mpc   [2];
  int          mage  [2];
  int          mend  [2];
  bit          msm   [2];
  logic [19:0] mbuf  [2][16];

  task automatic model_step(input int k);
    int ic;
    ic = (k == 0) ? ICA : ICB;
    if (rst) begin
      mmode[k] = 0; mpc[k] = 0; mage[k] = 0;
    end else begin
      case (mmode[k])
        0: begin
          if (load_en) mbuf[k][load_addr] = load_data;
          if (start) begin
            mmode[k] = 1; mpc[k] = 0; mage[k] = 0;
            mend[k] = int'(end_addr); msm[k] = step_mode;
          end
        end
        1: begin
          if (abort) mmode[k] = 0;
          else if (mage[k] == ic - 1) begin
            if (mpc[k] == mend[k]) mmode[k] = 3;
            else begin
              mpc[k] = mpc[k] + 1; mage[k] = 0;
              mmode[k] = msm[k] ? 2 : 1;
            end
          end else mage[k] = mage[k] + 1;
        end
        2: begin
          if (abort) mmode[k] = 0;
          else if (step) begin mmode[k] = 1; mage[k] = 0; end
        end
        default: mmode[k] = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  function automatic logic [19:0] exp_ins(input int k);
    return (mmode[k] == 1) ? mbuf[k][mpc[k]] : 20'h00000;
  endfunction
  function automatic logic exp_busy(input int k);
    return (mmode[k] == 1 || mmode[k] == 2);
  endfunction

  function automatic logic [19:0] out_ins(input int k);  return k == 0 ? a_ins : b_ins;     endfunction
  function automatic logic        out_val(input int k);  return k == 0 ? a_valid : b_valid; endfunction
  function automatic logic        out_busy(input int k); return k == 0 ? a_busy : b_busy;   endfunction
  function automatic logic        out_done(input int k); return k == 0 ? a_done : b_done;   endfunction
  function automatic logic [3:0]  out_pc(input int k);   return k == 0 ? a_pc : b_pc;       endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "A" : "B";
        chk({p, ".instruction"}, 32'(out_ins(k)), 32'(exp_ins(k)));
        chk({p, ".instr_valid"}, 32'(out_val(k)), 32'(mmode[k] == 1));
        chk({p, ".busy"}, 32'(out_busy(k)), 32'(exp_busy(k)));
        chk({p, ".done"}, 32'(out_done(k)), 32'(mmode[k] == 3));
        chk({p, ".pc"}, 32'(out_pc(k)), 32'(mpc[k]));
      end
    end
  end

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    int nv, nd, done_at;
    rst = 1'b1;
    repeat (2) nc();
    chk_en = 1'b1;
    chk("rst.instruction", 32'(a_ins), 32'h0);
    chk("rst.pc", 32'(a_pc), 0);
    chk("rst.busy", 32'(a_busy), 0);
    chk("rst.done", 32'(a_done), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = word(i);
      nc();
    end
    load_en = 1'b0;
    nc();

    // Free-run over three words
    end_addr = 4'd2; step_mode = 1'b0; start = 1'b1; nc(); start = 1'b0;
    chk("model.first_word", 32'(exp_ins(0)), 32'h10001);
    nv = 0; nd = 0; done_at = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 9) chk("free.word", 32'(a_ins), 32'(word(c / 3)));
      if (a_valid) nv++;
      if (a_done) begin
        nd++; done_at = c;
        chk("free.busy_at_done", 32'(a_busy), 0);
      end
      nc();
    end
    chk("free.valid_cycles", 32'(nv), 9);
    chk("free.done_count", 32'(nd), 1);
    chk("free.done_cycle", 32'(done_at), 9);

    // Single-step
    step_mode = 1'b1; start = 1'b1; nc(); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("step.hold", 32'(a_ins), 32'h10001);
      nc();
    end
    for (int c = 3; c < 8; c++) begin
      chk("step.wait_ins", 32'(a_ins), 32'h0);
      chk("step.wait_valid", 32'(a_valid), 0);
      chk("step.wait_busy", 32'(a_busy), 1);
      nc();
    end
    chk("model.wait_busy", 32'(exp_busy(0)), 1);
    step = 1'b1; nc(); step = 1'b0;
    chk("step.released_ins", 32'(a_ins), 32'h20002);
    chk("step.released_pc", 32'(a_pc), 1);
    abort = 1'b1; nc(); abort = 1'b0;
    chk("step.abort_busy", 32'(a_busy), 0);
    repeat (3) nc();

    // Abort in the second hold cycle of pc=1
    step_mode = 1'b0; end_addr = 4'd2; start = 1'b1; nc(); start = 1'b0;
    repeat (4) nc();
    chk("abort.pre_ins", 32'(a_ins), 32'h20002);
    abort = 1'b1; nc(); abort = 1'b0;
    chk("abort.ins", 32'(a_ins), 32'h0);
    chk("abort.busy", 32'(a_busy), 0);
    chk("abort.pc", 32'(a_pc), 1);
    nd = 0;
    repeat (6) begin
      if (a_done) nd++;
      nc();
    end
    chk("abort.no_done", 32'(nd), 0);
    start = 1'b1; nc(); start = 1'b0;
    chk("abort.restart_pc", 32'(a_pc), 0);
    chk("abort.restart_ins", 32'(a_ins), 32'h10001);
    repeat (12) nc();

    // Writes while busy must be dropped
    start = 1'b1; nc(); start = 1'b0;
    load_en = 1'b1; load_addr = 4'd0; load_data = 20'hFFFFF; nc(); load_en = 1'b0;
    repeat (12) nc();
    start = 1'b1; nc(); start = 1'b0;
    chk("guard.rerun_a", 32'(a_ins), 32'h10001);
    chk("guard.rerun_b", 32'(b_ins), 32'h10001);
    repeat (12) nc();

    // Whole buffer on the single-cycle instance
    end_addr = 4'd15; start = 1'b1; nc(); start = 1'b0;
    nd = 0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        chk("bound.word", 32'(b_ins), 32'(word(c)));
        chk("bound.pc", 32'(b_pc), 32'(c));
      end else begin
        chk("bound.pc_stop", 32'(b_pc), 15);
        chk("bound.valid_off", 32'(b_valid), 0);
      end
      if (b_done) nd++;
      nc();
    end
    chk("bound.done_count", 32'(nd), 1);
    repeat (40) nc();
    chk("bound.a_pc_stop", 32'(a_pc), 15);
    chk("bound.a_idle", 32'(a_busy), 0);

    // Reset while waiting for a step
    end_addr = 4'd5; step_mode = 1'b1; start = 1'b1; nc(); start = 1'b0;
    repeat (5) nc();
    chk("rstmid.pre_busy", 32'(a_busy), 1);
    rst = 1'b1; nc(); rst = 1'b0;
    chk("rstmid.ins", 32'(a_ins), 32'h0);
    chk("rstmid.pc", 32'(a_pc), 0);
    chk("rstmid.busy", 32'(a_busy), 0);
    chk("rstmid.done", 32'(a_done), 0);
    step_mode = 1'b0; end_addr = 4'd2; start = 1'b1; nc(); start = 1'b0;
    chk("rstmid.rerun", 32'(a_ins), 32'h10001);
    repeat (12) nc();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = 4'($urandom_range(0, 15));
      load_data = 20'($urandom);
      start     = ($urandom_range(0, 9) == 0);
      end_addr  = 4'($urandom_range(0, 15));
      step_mode = 1'($urandom_range(0, 1));
      step      = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      nc();
    end
    rst = 1'b0; load_en = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b0;
    repeat (4) nc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
